// File: rtl/nmr_bstrm_arb_ctrl_if.sv
// nmr_bstrm_arb_ctrl_if: command-memory read port plus the command/handshake
// bundle between the sequence fetcher and the arbitrary-bitstream datapath.
//   MEM_ADDR/MEM_RDEN  read request to SRAM (data valid one cycle later)
//   MEM_RDATA          {eos, all_0, all_1, pattern, data}
//   DPATH_START        one-cycle start pulse for the datapath
//   data/*_mode/end_of_sequence  registered command presented to the datapath
//   DPATH_BUF_RDY      datapath has buffered the presented command
//   DPATH_DONE         datapath idle flag
// master = fetcher side, slave = memory/datapath side.
interface nmr_bstrm_arb_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 120,
  parameter int unsigned ADDR_WIDTH = 10
);
  logic [ADDR_WIDTH-1:0] MEM_ADDR;
  logic                  MEM_RDEN;
  logic [DATA_WIDTH+3:0] MEM_RDATA;
  logic                  DPATH_START;
  logic [DATA_WIDTH-1:0] data;
  logic                  pattern_mode;
  logic                  all_1_mode;
  logic                  all_0_mode;
  logic                  end_of_sequence;
  logic                  DPATH_BUF_RDY;
  logic                  DPATH_DONE;

  modport master (
    output MEM_ADDR, MEM_RDEN, DPATH_START,
    output data, pattern_mode, all_1_mode, all_0_mode, end_of_sequence,
    input  MEM_RDATA, DPATH_BUF_RDY, DPATH_DONE
  );

  modport slave (
    input  MEM_ADDR, MEM_RDEN, DPATH_START,
    input  data, pattern_mode, all_1_mode, all_0_mode, end_of_sequence,
    output MEM_RDATA, DPATH_BUF_RDY, DPATH_DONE
  );
endinterface

// File: rtl/nmr_bstrm_arb_ctrl.sv
// nmr_bstrm_arb_ctrl: walks a command memory from START_ADDR, presents one
// command word at a time to the bitstream datapath, fetches the next word on
// DPATH_BUF_RDY, stops on end_of_sequence (or on address-space exhaustion,
// substituting a forced end word and flagging ERR) and pulses DONE once the
// datapath has drained.
// Ports:
//   CLK, RST     clock, asynchronous active-high reset
//   GO           start request (only honoured while idle)
//   START_ADDR   first command address, captured on accepted GO
//   bus          memory read port and datapath command/handshake (master)
//   BUSY         sequence in progress
//   DONE         one-cycle completion pulse
//   ERR          sticky exhaustion flag, cleared on the next accepted GO
//   WORD_CNT     words presented in the current or last run
module nmr_bstrm_arb_ctrl #(
  parameter int unsigned DATA_WIDTH = 120,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  GO,
  input  logic [ADDR_WIDTH-1:0] START_ADDR,
  nmr_bstrm_arb_ctrl_if.master  bus,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ERR,
  output logic [ADDR_WIDTH:0]   WORD_CNT
);
  localparam int unsigned WORD_WIDTH = DATA_WIDTH + 4;
  localparam logic [ADDR_WIDTH:0] FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [WORD_WIDTH-1:0] FORCED_EOS = {1'b1, {(WORD_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, FETCH, WAITRD, LOAD, RUN, DRAIN} state_t;

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] addr;
  logic [WORD_WIDTH-1:0] cmd;
  logic                  seen_low;
  logic                  first_word;
  logic                  mem_full;
  logic                  drain_ok;

  // WORD_CNT is bumped on entry to LOAD, so a count of one in LOAD marks
  // the first word of the run without a separate flag.
  assign first_word = (WORD_CNT == (ADDR_WIDTH+1)'(1));
  assign mem_full   = (WORD_CNT == FULL_CNT);
  assign drain_ok   = seen_low && bus.DPATH_DONE;

  assign bus.MEM_ADDR        = addr;
  assign bus.data            = cmd[DATA_WIDTH-1:0];
  assign bus.pattern_mode    = cmd[DATA_WIDTH];
  assign bus.all_1_mode      = cmd[DATA_WIDTH+1];
  assign bus.all_0_mode      = cmd[DATA_WIDTH+2];
  assign bus.end_of_sequence = cmd[DATA_WIDTH+3];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    bus.MEM_RDEN    = 1'b0;
    bus.DPATH_START = 1'b0;
    unique case (state)
      IDLE:   if (GO) state_nxt = FETCH;
      FETCH: begin
        bus.MEM_RDEN = 1'b1;
        state_nxt    = WAITRD;
      end
      WAITRD: state_nxt = LOAD;
      LOAD: begin
        bus.DPATH_START = first_word;
        state_nxt       = cmd[WORD_WIDTH-1] ? DRAIN : RUN;
      end
      // A word reaching RUN never carries end_of_sequence, so a full count
      // here means the address space is spent without a terminator.
      RUN:    if (bus.DPATH_BUF_RDY) state_nxt = mem_full ? DRAIN : FETCH;
      DRAIN:  if (drain_ok) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      addr     <= '0;
      cmd      <= '0;
      WORD_CNT <= '0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      ERR      <= 1'b0;
      seen_low <= 1'b0;
    end else begin
      DONE <= 1'b0;

      // Restart the "datapath went busy" tracking at the start pulse; a
      // datapath may keep DPATH_DONE high for a couple of cycles after it.
      if (state == LOAD && first_word) seen_low <= 1'b0;
      else if (!bus.DPATH_DONE)        seen_low <= 1'b1;

      if (state == IDLE && GO) begin
        addr     <= START_ADDR;
        WORD_CNT <= '0;
        ERR      <= 1'b0;
        BUSY     <= 1'b1;
      end

      if (state == WAITRD) begin
        cmd      <= bus.MEM_RDATA;
        WORD_CNT <= WORD_CNT + 1'b1;
        addr     <= addr + 1'b1;
      end

      if (state == RUN && bus.DPATH_BUF_RDY && mem_full) begin
        cmd <= FORCED_EOS;
        ERR <= 1'b1;
      end

      if (state == DRAIN && drain_ok) begin
        DONE <= 1'b1;
        BUSY <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_nmr_bstrm_arb_ctrl.sv
// Testbench for nmr_bstrm_arb_ctrl: SRAM and datapath behavioural models,
// scoreboard queues filled from a sequence-level reference model, and an
// independent monitor that checks fetch addresses, presented commands,
// start pulses and completion records.
module tb_nmr_bstrm_arb_ctrl;
  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 3;
  localparam int unsigned WW    = DW + 4;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk;
  logic          rst;
  logic          go;
  logic [AW-1:0] start_addr;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW:0]   word_cnt;

  nmr_bstrm_arb_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  nmr_bstrm_arb_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .CLK(clk), .RST(rst), .GO(go), .START_ADDR(start_addr), .bus(bus),
    .BUSY(busy), .DONE(done), .ERR(err), .WORD_CNT(word_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // word layout: [35] eos, [34] all_0, [33] all_1, [32] pattern, [31:0] data
  logic [WW-1:0] mem [DEPTH];
  always @(posedge clk) if (bus.MEM_RDEN) bus.MEM_RDATA <= mem[bus.MEM_ADDR];

  logic [WW-1:0] cur_word;
  assign cur_word = {bus.end_of_sequence, bus.all_0_mode, bus.all_1_mode,
                     bus.pattern_mode, bus.data};

  typedef struct { logic [WW-1:0] w; logic first; } cmd_t;
  typedef struct { logic [WW-1:0] w; logic [AW:0] cnt; logic err; } done_t;

  logic [AW-1:0] q_addr [$];
  cmd_t          q_cmd  [$];
  done_t         q_done [$];
  int unsigned   done_seen;
  int unsigned   n_pass;
  int unsigned   n_total;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: walk memory from start until an end word or until
  // every address has been read once; a missing terminator yields the
  // forced all-zero end word and ERR.
  task automatic expect_run(input logic [AW-1:0] start, output int unsigned n, output bit forced);
    logic [WW-1:0] words [$];
    logic [AW-1:0] a;
    cmd_t          c;
    done_t         d;
    a = start;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      q_addr.push_back(a);
      words.push_back(mem[a]);
      if (mem[a][WW-1]) break;
      a = a + 1'b1;
    end
    n      = words.size();
    forced = !words[n-1][WW-1];
    for (int unsigned i = 0; i < n; i++) begin
      c.w     = words[i];
      c.first = (i == 0);
      q_cmd.push_back(c);
    end
    d.w   = forced ? {1'b1, {(WW-1){1'b0}}} : words[n-1];
    d.cnt = (AW+1)'(n);
    d.err = forced;
    q_done.push_back(d);
  endtask

  task automatic flush();
    q_addr.delete();
    q_cmd.delete();
    q_done.delete();
  endtask

  task automatic fill_random(input logic [AW-1:0] start, input int unsigned eos_k, input bit with_eos);
    logic [AW-1:0] p;
    for (int unsigned i = 0; i < DEPTH; i++) mem[i] = {1'b0, 3'($urandom), 32'($urandom)};
    p = start + AW'(eos_k);
    if (with_eos) mem[p][WW-1] = 1'b1;
  endtask

  // Monitor: commands must appear two cycles after their read strobe.
  initial begin
    logic  d1, d2;
    cmd_t  c;
    done_t d;
    d1 = 1'b0;
    d2 = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        d1 = 1'b0;
        d2 = 1'b0;
      end else begin
        if (bus.MEM_RDEN) begin
          check("fetch_expected", q_addr.size() > 0, 1'b1);
          if (q_addr.size() > 0) check("fetch_addr", bus.MEM_ADDR, q_addr.pop_front());
        end
        if (d2) begin
          check("cmd_expected", q_cmd.size() > 0, 1'b1);
          if (q_cmd.size() > 0) begin
            c = q_cmd.pop_front();
            check("cmd_word", cur_word, c.w);
            check("dpath_start", bus.DPATH_START, c.first);
          end
        end else begin
          check("dpath_start_quiet", bus.DPATH_START, 1'b0);
        end
        if (done) begin
          done_seen++;
          check("done_expected", q_done.size() > 0, 1'b1);
          if (q_done.size() > 0) begin
            d = q_done.pop_front();
            check("done_word", cur_word, d.w);
            check("done_word_cnt", word_cnt, d.cnt);
            check("done_err", err, d.err);
          end
        end
        d2 = d1;
        d1 = bus.MEM_RDEN;
      end
    end
  end

  task automatic wait_start(output int unsigned guard);
    guard = 0;
    while (!bus.DPATH_START && guard < 10) begin
      @(negedge clk);
      guard++;
    end
  endtask

  task automatic issue_go(input logic [AW-1:0] start);
    @(negedge clk);
    go         = 1'b1;
    start_addr = start;
    @(negedge clk);
    go         = 1'b0;
    start_addr = 3'($urandom);
  endtask

  task automatic run_seq(input logic [AW-1:0] start, input int unsigned drop_dly);
    int unsigned n, hold, guard, dly, d0;
    bit          forced;
    expect_run(start, n, forced);
    issue_go(start);
    check("busy_after_go", busy, 1'b1);
    check("err_clear_on_go", err, 1'b0);
    check("word_cnt_clear_on_go", word_cnt, 0);
    wait_start(guard);
    check("go_to_start_cycles", guard, 2);
    if (!bus.DPATH_START) begin
      flush();
      return;
    end
    dly = (drop_dly != 0) ? drop_dly : 1 + $urandom % 2;
    repeat (dly) @(negedge clk);
    bus.DPATH_DONE = 1'b0;
    for (int unsigned idx = 0; idx < n; idx++) begin
      if (idx == n - 1 && !forced) break;
      if (idx == 0) begin
        go         = 1'b1;
        start_addr = start + 3'd3;
        @(negedge clk);
        go = 1'b0;
      end
      repeat ($urandom % 3) @(negedge clk);
      hold = 1 + $urandom % 3;
      bus.DPATH_BUF_RDY = 1'b1;
      @(negedge clk);
      if (idx < n - 1) begin
        check("rdy_to_rden", bus.MEM_RDEN, 1'b1);
      end else begin
        check("exhaust_no_fetch", bus.MEM_RDEN, 1'b0);
        check("forced_eos", bus.end_of_sequence, 1'b1);
        check("err_set", err, 1'b1);
      end
      repeat (hold - 1) @(negedge clk);
      bus.DPATH_BUF_RDY = 1'b0;
      repeat (4 - hold) @(negedge clk);
    end
    bus.DPATH_BUF_RDY = 1'b1;
    repeat (2) @(negedge clk);
    bus.DPATH_BUF_RDY = 1'b0;
    repeat (1 + $urandom % 3) @(negedge clk);
    check("busy_while_drain", busy, 1'b1);
    d0 = done_seen;
    bus.DPATH_DONE = 1'b1;
    @(negedge clk);
    check("done_after_dpath_done", done, 1'b1);
    check("busy_clear_at_done", busy, 1'b0);
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);
    check("done_count", done_seen, d0 + 1);
    guard = 0;
    while (busy && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (busy) flush();
  endtask

  task automatic mid_reset(input logic [AW-1:0] start);
    int unsigned n, guard, d0;
    bit          forced;
    fill_random(start, 5, 1'b1);
    expect_run(start, n, forced);
    issue_go(start);
    wait_start(guard);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_rden", bus.MEM_RDEN, 1'b0);
    check("abort_start", bus.DPATH_START, 1'b0);
    check("abort_addr", bus.MEM_ADDR, 0);
    check("abort_cmd", cur_word, 0);
    check("abort_busy", busy, 1'b0);
    check("abort_err", err, 1'b0);
    check("abort_word_cnt", word_cnt, 0);
    flush();
    bus.DPATH_DONE    = 1'b1;
    bus.DPATH_BUF_RDY = 1'b0;
    d0 = done_seen;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("no_done_after_abort", done_seen, d0);
    check("idle_after_abort", busy, 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [AW-1:0] s;
    n_pass            = 0;
    n_total           = 0;
    done_seen         = 0;
    rst               = 1'b1;
    go                = 1'b0;
    start_addr        = '0;
    bus.DPATH_BUF_RDY = 1'b0;
    bus.DPATH_DONE    = 1'b1;
    for (int unsigned i = 0; i < DEPTH; i++) mem[i] = '0;
    repeat (2) @(negedge clk);
    check("rst_mem_addr", bus.MEM_ADDR, 0);
    check("rst_mem_rden", bus.MEM_RDEN, 1'b0);
    check("rst_dpath_start", bus.DPATH_START, 1'b0);
    check("rst_cmd", cur_word, 0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_word_cnt", word_cnt, 0);
    rst = 1'b0;
    @(negedge clk);

    // all_1 length 10, pattern 0xA5, end word
    mem[5] = {4'b0010, 32'd10};
    mem[6] = {4'b0001, 32'h0000_00A5};
    mem[7] = {4'b1000, 32'd0};
    run_seq(3'd5, 0);
    check("three_word_err", err, 1'b0);
    check("three_word_cnt", word_cnt, 3);

    // single end word with the datapath dropping DONE two cycles late
    s = 3'($urandom);
    fill_random(s, 0, 1'b1);
    run_seq(s, 2);

    for (int unsigned r = 0; r < 8; r++) begin
      s = 3'($urandom);
      fill_random(s, $urandom % DEPTH, 1'b1);
      run_seq(s, 0);
    end

    // no terminator anywhere: wraps through the whole space
    s = 3'(1 + $urandom % (DEPTH - 1));
    fill_random(s, 0, 1'b0);
    run_seq(s, 0);
    repeat (3) @(negedge clk);
    check("err_sticky", err, 1'b1);
    check("exhaust_word_cnt", word_cnt, DEPTH);

    s = 3'($urandom);
    fill_random(s, 2, 1'b1);
    run_seq(s, 0);
    check("err_cleared_run", err, 1'b0);

    mid_reset(3'($urandom));

    s = 3'($urandom);
    fill_random(s, 3, 1'b1);
    run_seq(s, 0);

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
